// File: rtl/named_accum_pipe.sv
// Two-stage pipelined running-offset adder: XOUT = (A + B) - CNT with valid/ready flow control.
// Define NAMED_ACCUM_SAT_EN to clamp the result to [0, 2^NBITS-1] instead of wrapping.
module named_accum_pipe #(
    parameter int          NBITS = 8,
    parameter int unsigned STEP  = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [NBITS-1:0] A,
    input  logic [NBITS-1:0] B,
    input  logic             VALID_IN,
    output logic             READY,
    input  logic             CLEAR,
    output logic [NBITS-1:0] XOUT,
    output logic             VALID_OUT,
    input  logic             READY_IN
);

    localparam logic [NBITS-1:0] STEP_N = NBITS'(STEP);

    logic             advance;
    logic             in_xfer;
    logic [NBITS-1:0] cnt_reg;
    logic [NBITS-1:0] cnt_next;
    logic             s1_valid_reg;
    logic [NBITS:0]   s1_sum_reg;
    logic [NBITS-1:0] s1_cnt_reg;
    logic [NBITS+1:0] diff;
    logic [NBITS-1:0] xout_next;
    logic             valid_out_reg;
    logic [NBITS-1:0] xout_reg;

    // The whole pipe moves as one unit: it only stalls when a valid result is refused.
    assign advance   = !valid_out_reg || READY_IN;
    assign READY     = advance;
    assign in_xfer   = VALID_IN && advance;
    assign VALID_OUT = valid_out_reg;
    assign XOUT      = xout_reg;

    // A clear coinciding with a sample restarts the count, so that sample sees STEP.
    always_comb begin
        cnt_next = cnt_reg;
        if (in_xfer) begin
            cnt_next = (CLEAR ? '0 : cnt_reg) + STEP_N;
        end else if (CLEAR) begin
            cnt_next = '0;
        end
    end

    // Two extra bits keep both the sum carry and the sign of the difference.
    assign diff = {1'b0, s1_sum_reg} - {2'b00, s1_cnt_reg};

`ifdef NAMED_ACCUM_SAT_EN
    always_comb begin
        xout_next = diff[NBITS-1:0];
        if (diff[NBITS+1]) begin
            xout_next = '0;
        end else if (diff[NBITS]) begin
            xout_next = '1;
        end
    end
`else
    logic unused_diff_msbs;
    assign unused_diff_msbs = ^diff[NBITS+1:NBITS];
    assign xout_next        = diff[NBITS-1:0];
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_reg       <= '0;
            s1_valid_reg  <= 1'b0;
            s1_sum_reg    <= '0;
            s1_cnt_reg    <= '0;
            valid_out_reg <= 1'b0;
            xout_reg      <= '0;
        end else begin
            cnt_reg <= cnt_next;
            if (advance) begin
                s1_valid_reg  <= in_xfer;
                s1_sum_reg    <= {1'b0, A} + {1'b0, B};
                s1_cnt_reg    <= cnt_next;
                valid_out_reg <= s1_valid_reg;
                xout_reg      <= xout_next;
            end
        end
    end

endmodule
